// File: rtl/processor_core.sv
// Single-cycle register-file ALU core: 32 x 16-bit GPRs, an SGPR holding the
// upper half of multiply products, and a registered {sign, zero, overflow, carry} flag set.
module processor_core #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] sgpr,
    output logic [3:0]        flags
);

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_OR      = 5'd5,
        OP_AND     = 5'd6,
        OP_XOR     = 5'd7,
        OP_XNOR    = 5'd8,
        OP_NAND    = 5'd9,
        OP_NOR     = 5'd10,
        OP_NOT     = 5'd11
    } opcode_t;

    logic [DATA_W-1:0]   gpr [NUM_REGS];

    opcode_t             opcode;
    logic [4:0]          rdst;
    logic [4:0]          rsrc1;
    logic [4:0]          rsrc2;
    logic                imm_mode;
    logic [15:0]         imm;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] product;

    logic [DATA_W-1:0]   result;
    logic                result_we;
    logic                flags_we;
    logic                sgpr_we;
    logic                carry;
    logic                overflow;
    logic                zero;
    logic [3:0]          next_flags;

    assign opcode   = opcode_t'(instr[31:27]);
    assign rdst     = instr[26:22];
    assign rsrc1    = instr[21:17];
    assign imm_mode = instr[16];
    assign rsrc2    = instr[15:11];
    assign imm      = instr[15:0];

    // Sources come straight from the array, so a write to rdst lands after they are used.
    assign op_a    = gpr[rsrc1];
    assign op_b    = imm_mode ? DATA_W'(imm) : gpr[rsrc2];
    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign diff    = op_a - op_b;
    assign product = op_a * op_b;

    assign dbg_data = gpr[dbg_addr];

    always_comb begin
        result    = '0;
        result_we = 1'b0;
        flags_we  = 1'b0;
        sgpr_we   = 1'b0;
        carry     = 1'b0;
        overflow  = 1'b0;
        case (opcode)
            OP_MOVSGPR: begin
                result    = sgpr;
                result_we = 1'b1;
            end
            OP_MOV: begin
                // Register MOV copies rsrc1, not rsrc2.
                result    = imm_mode ? op_b : op_a;
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_ADD: begin
                result    = sum[DATA_W-1:0];
                carry     = sum[DATA_W];
                overflow  = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                            (sum[DATA_W-1] != op_a[DATA_W-1]);
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_SUB: begin
                result    = diff;
                overflow  = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                            (diff[DATA_W-1] != op_a[DATA_W-1]);
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_MUL: begin
                result    = product[DATA_W-1:0];
                result_we = 1'b1;
                flags_we  = 1'b1;
                sgpr_we   = 1'b1;
            end
            OP_OR: begin
                result    = op_a | op_b;
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_AND: begin
                result    = op_a & op_b;
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_XOR: begin
                result    = op_a ^ op_b;
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_XNOR: begin
                result    = ~(op_a ^ op_b);
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_NAND: begin
                result    = ~(op_a & op_b);
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_NOR: begin
                result    = ~(op_a | op_b);
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            OP_NOT: begin
                result    = ~op_a;
                result_we = 1'b1;
                flags_we  = 1'b1;
            end
            default: begin
            end
        endcase
        // Multiply reports zero on the whole product, not just the low half.
        zero       = (opcode == OP_MUL) ? (product == '0) : (result == '0);
        next_flags = {result[DATA_W-1], zero, overflow, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
            sgpr  <= '0;
            flags <= '0;
        end else if (instr_valid) begin
            if (result_we) begin
                gpr[rdst] <= result;
            end
            if (sgpr_we) begin
                sgpr <= product[2*DATA_W-1:DATA_W];
            end
            if (flags_we) begin
                flags <= next_flags;
            end
        end
    end

endmodule

// File: tb/tb_processor_core.sv
// Randomized scoreboard bench for processor_core: stimulus pushes model-predicted
// state into a queue, a monitor pops and compares after every accepted or reset edge.
module tb_processor_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic [15:0] sgpr;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    processor_core dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .sgpr        (sgpr),
        .flags       (flags)
    );

    typedef struct {
        bit          sweep;
        logic [4:0]  addr;
        logic [15:0] data;
        logic [15:0] sgpr_v;
        logic [3:0]  flags_v;
        logic [511:0] snap;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_regs [32];
    logic [15:0] m_sgpr;
    logic [3:0]  m_flags;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic im,
                                        input logic [15:0] low);
        return {op, rd, rs1, im, low};
    endfunction

    function automatic logic [31:0] reg_op(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'h000};
    endfunction

    function automatic int s16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_sgpr  = '0;
        m_flags = '0;
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model_exec(input logic [31:0] ins);
        int op, rd, rs1, rs2, a, b, res, s;
        bit im, wr, fl, c, v, z;
        longint p;
        op  = int'(ins[31:27]);
        rd  = int'(ins[26:22]);
        rs1 = int'(ins[21:17]);
        im  = ins[16];
        rs2 = int'(ins[15:11]);
        a   = int'(m_regs[rs1]);
        b   = im ? int'(ins[15:0]) : int'(m_regs[rs2]);
        wr  = 1; fl = 1; c = 0; v = 0; p = 1; res = 0;
        case (op)
            0:  begin res = int'(m_sgpr); fl = 0; end
            1:  res = im ? b : a;
            2:  begin
                    res = a + b;
                    c = (res > 65535);
                    s = s16(a) + s16(b);
                    v = (s > 32767) || (s < -32768);
                end
            3:  begin
                    res = a - b;
                    s = s16(a) - s16(b);
                    v = (s > 32767) || (s < -32768);
                end
            4:  begin
                    p = longint'(a) * longint'(b);
                    res = int'(p % 65536);
                    m_sgpr = 16'(p / 65536);
                end
            5:  res = a | b;
            6:  res = a & b;
            7:  res = a ^ b;
            8:  res = ~(a ^ b);
            9:  res = ~(a & b);
            10: res = ~(a | b);
            11: res = ~a;
            default: begin wr = 0; fl = 0; end
        endcase
        res = res & 65535;
        z = (op == 4) ? (p == 0) : (res == 0);
        if (wr) m_regs[rd] = 16'(res);
        if (fl) m_flags = {res >= 32768, z, v, c};
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input bit valid,
                                 input bit do_rst, input bit sweep);
        exp_t e;
        @(negedge clk);
        instr       = ins;
        instr_valid = valid;
        rst         = do_rst;
        if (do_rst) model_reset();
        else if (valid) model_exec(ins);
        if (valid || do_rst) begin
            e.sweep   = sweep;
            e.addr    = ins[26:22];
            e.data    = m_regs[ins[26:22]];
            e.sgpr_v  = m_sgpr;
            e.flags_v = m_flags;
            for (int i = 0; i < 32; i++) e.snap[i*16 +: 16] = m_regs[i];
            exp_q.push_back(e);
        end
        // A full register sweep needs idle cycles; garbage on instr must be ignored.
        if (sweep) begin
            @(negedge clk);
            rst         = 1'b0;
            instr_valid = 1'b0;
            instr       = $urandom;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (!e.sweep) begin
            dbg_addr = e.addr;
            #1;
            check_val($sformatf("gpr[%0d]", e.addr), dbg_data, e.data);
        end else begin
            for (int i = 0; i < 32; i++) begin
                dbg_addr = 5'(i);
                #1;
                check_val($sformatf("sweep gpr[%0d]", i), dbg_data, e.snap[i*16 +: 16]);
            end
        end
        check_val("sgpr", sgpr, e.sgpr_v);
        check_val("flags", {12'h000, flags}, {12'h000, e.flags_v});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (instr_valid || rst) begin
                #3;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: got empty queue expected pending item at %0t", $time);
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] ins;
        logic [15:0] low;
        int op;
        bit valid;

        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        for (int r = 0; r < 32; r++) begin
            applyStimulus(enc(5'd1, 5'(r), 5'd0, 1'b1, 16'd2), 1'b1, 1'b0, r == 31);
        end

        applyStimulus(enc(5'd2, 5'd0, 5'd2, 1'b1, 16'd4), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd4, 5'd0, 1'b1, 16'd55), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd4, 5'd7, 1'b0, 16'h0000), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd6, 5'd4, 5'd7, 1'b1, 16'd56), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd7, 5'd4, 5'd7, 1'b1, 16'd56), 1'b1, 1'b0, 1'b0);
        applyStimulus(reg_op(5'd5, 5'd0, 5'd16, 5'd4), 1'b1, 1'b0, 1'b0);
        applyStimulus(reg_op(5'd10, 5'd0, 5'd16, 5'd4), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd5, 5'd0, 1'b1, 16'h0100), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd4, 5'd0, 5'd5, 1'b1, 16'h0100), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd0, 5'd3, 5'd0, 1'b0, 16'h0000), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd6, 5'd0, 1'b1, 16'hFFFF), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd2, 5'd7, 5'd6, 1'b1, 16'h0001), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd8, 5'd0, 1'b1, 16'h8000), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd3, 5'd9, 5'd8, 1'b1, 16'h0001), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd12, 5'd9, 5'd8, 1'b1, 16'h0001), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd31, 5'd7, 5'd8, 1'b1, 16'h1234), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd9, 5'd0, 1'b1, 16'h1234), 1'b0, 1'b0, 1'b0);
        applyStimulus(enc(5'd13, 5'd0, 5'd0, 1'b0, 16'h0000), 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 13);
            if (op >= 12) op = $urandom_range(12, 31);
            case ($urandom_range(0, 5))
                0:       low = 16'hFFFF;
                1:       low = 16'h8000;
                2:       low = 16'h0000;
                default: low = 16'($urandom);
            endcase
            ins   = enc(5'(op), 5'($urandom), 5'($urandom), 1'($urandom), low);
            valid = ($urandom_range(0, 4) != 0);
            applyStimulus(ins, valid, 1'b0, valid && (n % 100 == 99));
        end

        applyStimulus(enc(5'd1, 5'd10, 5'd0, 1'b1, 16'hBEEF), 1'b1, 1'b0, 1'b0);
        applyStimulus(enc(5'd1, 5'd11, 5'd0, 1'b1, 16'h1111), 1'b1, 1'b1, 1'b1);
        applyStimulus(enc(5'd2, 5'd12, 5'd12, 1'b1, 16'h0007), 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        instr_valid = 1'b0;
        rst         = 1'b0;
        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending items expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_core.md
Name: processor_core

Overview:
- Single-cycle register-file ALU core executing one 32-bit instruction per accepted clock.
- Contains 32 general-purpose registers (GPR, 16-bit), a special register (SGPR) for the upper half of multiply results, and a 4-bit condition-flag register.
- Instructions are presented on an input port.
- Register contents are observable through a combinational debug read port, used by software bring-up and the verification bench.

Parameters:
- DATA_W, 16, GPR/SGPR/ALU data width.
- NUM_REGS, 32, number of GPRs; addressed by 5-bit fields.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word.
- instr_valid  in  1  execute instr at this rising edge when high.
- dbg_addr  in  5  debug read register index.
- dbg_data  out  16  GPR[dbg_addr], combinational.
- sgpr  out  16  current SGPR value.
- flags  out  4  {sign, zero, overflow, carry}, registered.

Behaviour:
Instruction fields:
- opcode = instr[31:27]
- rdst = instr[26:22]
- rsrc1 = instr[21:17]
- imm_mode = instr[16]
- rsrc2 = instr[15:11]
- imm = instr[15:0]

Operand selection:
- Operand A = GPR[rsrc1].
- Operand B = imm if imm_mode=1, else GPR[rsrc2].

Opcodes (result written to GPR[rdst] at the accepting edge):
- 00000 MOVSGPR: rdst <= SGPR.
- 00001 MOV: rdst <= B (imm or GPR[rsrc1] when imm_mode=0; register MOV uses rsrc1, not rsrc2).
- 00010 ADD: A+B.
- 00011 SUB: A-B.
- 00100 MUL: 32-bit product A*B (unsigned); rdst <= low 16 bits, SGPR <= high 16 bits.
- 00101 OR: A|B.
- 00110 AND: A&B.
- 00111 XOR: A^B.
- 01000 XNOR: ~(A^B).
- 01001 NAND: ~(A&B).
- 01010 NOR: ~(A|B).
- 01011 NOT: ~A.
- 01100–11111: no operation; no GPR, SGPR or flag change.

Arithmetic and width rules:
- All results are truncated to 16 bits.
- ADD/SUB wrap modulo 2^16.

Flags (updated only for opcodes 00001–01011, in the same cycle as the result):
- sign = result[15].
- zero = (result == 0); for MUL, result is the full 32-bit product.
- carry = carry-out of ADD (bit 16); 0 for other ops.
- overflow = two's-complement signed overflow for ADD/SUB; 0 for other ops.
- MOVSGPR leaves the flags unchanged.

Timing:
- Latency: result visible on dbg_data immediately after the accepting edge (one cycle).
- instr_valid=0: all state held.
- Sources are read before the write, so rdst == rsrc1/rsrc2 uses the old value.
- GPR[0] is a normal writable register (not hardwired to zero).

Reset:
- rst=1 at a rising edge clears all GPRs, SGPR and flags to 0, with priority over instr_valid.
- Reset mid-stream discards the instruction presented in that cycle.
- dbg_data therefore reads 0 for every register after reset.

Test Plan:
- Reset, then MOVI 2 into GPR[0..31] (opcode 00001, imm_mode=1) -> every dbg_data read = 2; flags zero=0.
- ADDI rdst=0, rsrc1=2, imm=4 -> GPR[0]=6; MOVI rdst=4, imm=55 -> GPR[4]=55.
- MOV register rdst=4, rsrc1=7 -> GPR[4]=2.
- ANDI rdst=4, rsrc1=7, imm=56 -> GPR[4]=0 with zero=1; then XORI rdst=4, rsrc1=7, imm=56 -> GPR[4]=58.
- Register-mode ops with GPR[16]=2, GPR[4]=58:
  - OR rdst=0, rsrc1=16, rsrc2=4 -> GPR[0]=58.
  - NOR same operands -> GPR[0]=0xFFC5 with sign=1.
- MUL 0x0100*0x0100 -> rdst=0x0000, SGPR=0x0001, zero=0; then MOVSGPR rdst=3 -> GPR[3]=1.
- ADD 0xFFFF+1 -> result 0, carry=1, zero=1.
- Assert rst while instr_valid=1 -> all registers read 0 next cycle.
